hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage cached CPU.
- Sits beside the forwarding unit and decides, each cycle, whether the PC and the IF/ID register advance, whether a bubble goes into ID/EX, and whether IF/ID is flushed.
- Covers three cases: load-use hazards, taken branches resolved in ID, and D-cache miss freezes.
- Also tracks miss duration, raises a sticky timeout flag, and keeps saturating performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.
- MISS_TIMEOUT, 1024, number of consecutive D-cache stall cycles that sets missTimeout_o (legal range 1 to 2^16-1).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- idRs1_i  input  5  rs1 of the instruction in ID.
- idRs2_i  input  5  rs2 of the instruction in ID.
- idUsesRs2_i  input  1  ID instruction reads rs2 (R/S/B types).
- exMemRead_i  input  1  instruction in EX is a load.
- exRd_i  input  5  rd of the instruction in EX.
- branchTaken_i  input  1  branch or jump resolved taken in ID.
- dcacheStall_i  input  1  D-cache is servicing a miss; the MEM access is not complete.
- clrCnt_i  input  1  synchronous clear of the performance counters.
- pcWrite_o  output  1  PC register enable.
- ifidWrite_o  output  1  IF/ID register enable.
- idexBubble_o  output  1  load NOP control into ID/EX.
- ifidFlush_o  output  1  clear IF/ID to a NOP.
- allStall_o  output  1  freeze every pipeline register (ID/EX, EX/MEM, MEM/WB).
- missTimeout_o  output  1  sticky; a miss exceeded MISS_TIMEOUT.
- stallCycles_o  output  CNT_W  cycles with allStall_o=1.
- missCnt_o  output  CNT_W  number of distinct misses.
- loadUseCnt_o  output  CNT_W  load-use bubbles inserted.
- flushCnt_o  output  CNT_W  IF/ID flushes issued.

Behaviour:
- Reset:
  - Asynchronous, active when rst_i=0. state=RUN, waitCnt=0, all counters=0, missTimeout_o=0.
  - While rst_i=0 the combinational outputs are forced: pcWrite_o=0, ifidWrite_o=0, idexBubble_o=1, ifidFlush_o=0, allStall_o=0.
- Hazard terms (combinational):
  - loadUse = exMemRead_i & (exRd_i!=0) & ((exRd_i==idRs1_i) | (idUsesRs2_i & exRd_i==idRs2_i)).
  - Note x0 never triggers a load-use stall.
- Output priority (combinational, zero latency), highest first:
  1. dcacheStall_i=1: allStall_o=1, pcWrite_o=0, ifidWrite_o=0, idexBubble_o=0, ifidFlush_o=0. This is a pure freeze; no bubble or flush is inserted, so a pending branch or load-use is re-evaluated after the freeze.
  2. loadUse=1: pcWrite_o=0, ifidWrite_o=0, idexBubble_o=1, ifidFlush_o=0. A simultaneous branchTaken_i is ignored this cycle; the branch re-resolves next cycle.
  3. branchTaken_i=1: pcWrite_o=1, ifidWrite_o=1, ifidFlush_o=1, idexBubble_o=0.
  4. Otherwise: pcWrite_o=1, ifidWrite_o=1, all other controls 0.
- FSM, 2 states: RUN and MISS_WAIT.
  - RUN with dcacheStall_i=1: go to MISS_WAIT, waitCnt<=1, missCnt++. If MISS_TIMEOUT==1, set missTimeout_o.
  - MISS_WAIT with dcacheStall_i=1: stay; waitCnt<=waitCnt+1, saturating at 2^16-1. Set missTimeout_o when waitCnt+1==MISS_TIMEOUT.
  - MISS_WAIT with dcacheStall_i=0: go to RUN, waitCnt<=0. This cycle is a normal, non-frozen cycle.
  - Back-to-back misses (stall deasserts for 1 cycle, then reasserts) count as 2 misses.
- missTimeout_o: sticky; cleared only by reset, not by clrCnt_i.
- Counters:
  - Registered; each increments at the clock edge after its cycle's condition holds.
  - stallCycles_o increments when allStall_o=1; loadUseCnt_o when priority-2 fires; flushCnt_o when priority-3 fires; missCnt_o as in the FSM.
  - Each counter saturates at all-ones and does not wrap.
  - clrCnt_i=1 zeroes all four counters. Clear wins over a same-cycle increment, so the result is 0.
- No output is registered except the counters and missTimeout_o.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - FSM state encoding (RUN=1'b0, MISS_WAIT=1'b1);
  - REG_ZERO=5'd0;
  - the forward/stall control widths shared with the forwarding unit.
- One sub-module, sat_counter (parameter W; ports inc, clr, q), instantiated four times.

Test Plan:
- Load-use: exMemRead_i=1, exRd_i=5, idRs1_i=5 → pcWrite_o=0, ifidWrite_o=0, idexBubble_o=1; loadUseCnt_o=1 next cycle. The same stimulus with exRd_i=0 gives no stall.
- rs2 gating: exRd_i=7, idRs2_i=7, idUsesRs2_i=0 → no stall. With idUsesRs2_i=1 → stall.
- Branch plus load-use in the same cycle: loadUse wins, ifidFlush_o=0. The next cycle, with exMemRead_i=0 and branchTaken_i=1 → ifidFlush_o=1, flushCnt_o=1.
- Miss: hold dcacheStall_i=1 for 5 cycles while loadUse=1 → allStall_o=1 and idexBubble_o=0 throughout; stallCycles_o=5, missCnt_o=1. After release, the bubble is issued.
- Timeout with MISS_TIMEOUT=4: stall 3 cycles → flag stays 0. A new miss stalling 4 cycles → missTimeout_o=1 after the 4th edge, and it stays 1 after clrCnt_i. Asserting rst_i=0 mid-miss → state=RUN, flag=0, counters=0 immediately.
- Saturation with CNT_W=3: 9 flush cycles → flushCnt_o=7. Assert clrCnt_i together with a flush → flushCnt_o=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared pipeline-control definitions for the hazard/stall controller and forwarding unit.
// Contents: FSM state encoding, architectural zero register, control-field widths.
// No logic; imported by every control-path module.
package cpu_ctrl_pkg;

    // Register-file address width and the hard-wired zero register.
    localparam int         REG_ADDR_W = 5;
    localparam logic [4:0] REG_ZERO   = 5'd0;

    // Forward-select and stall-control widths shared with the forwarding unit.
    localparam int FWD_SEL_W  = 2;
    localparam int STALL_CTL_W = 5;

    // Miss-duration tracker width and its saturation value.
    localparam int          WAIT_CNT_W   = 16;
    localparam logic [15:0] WAIT_CNT_MAX = 16'hFFFF;

    // Sequencer state: normal issue, or frozen on an outstanding D-cache miss.
    typedef enum logic {
        RUN       = 1'b0,
        MISS_WAIT = 1'b1
    } ctrl_state_t;

    // Per-cycle pipeline control bundle.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_bubble;
        logic ifid_flush;
        logic all_stall;
    } stall_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
// Ports: clk_i/rst_i (async active-low), inc, clr, q (W bits).
// Latency: q reflects inc/clr one clock edge later; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing: load-use bubbles, ID-branch flushes, D-cache miss freeze, miss timeout, perf counters.
// Ports: hazard inputs from ID/EX, dcacheStall_i, clrCnt_i; PC/IF-ID/ID-EX/freeze controls, sticky timeout, 4 counters.
// Controls are combinational (zero latency); only counters and missTimeout_o are registered.
module hazard_stall_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int MISS_TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       idRs1_i,
    input  logic [4:0]       idRs2_i,
    input  logic             idUsesRs2_i,
    input  logic             exMemRead_i,
    input  logic [4:0]       exRd_i,
    input  logic             branchTaken_i,
    input  logic             dcacheStall_i,
    input  logic             clrCnt_i,
    output logic             pcWrite_o,
    output logic             ifidWrite_o,
    output logic             idexBubble_o,
    output logic             ifidFlush_o,
    output logic             allStall_o,
    output logic             missTimeout_o,
    output logic [CNT_W-1:0] stallCycles_o,
    output logic [CNT_W-1:0] missCnt_o,
    output logic [CNT_W-1:0] loadUseCnt_o,
    output logic [CNT_W-1:0] flushCnt_o
);

    ctrl_state_t     r_state;
    ctrl_state_t     w_state_nxt;
    logic [15:0]     r_wait_cnt;
    logic [15:0]     w_wait_nxt;
    logic            r_timeout;
    logic            w_timeout_set;
    logic            w_miss_start;
    logic            w_load_use;
    logic            w_lu_fire;
    logic            w_flush_fire;
    stall_ctrl_t     w_ctrl;

    // x0 is never a real producer, so a load targeting it cannot create a hazard.
    assign w_load_use = exMemRead_i && (exRd_i != REG_ZERO) &&
                        ((exRd_i == idRs1_i) || (idUsesRs2_i && (exRd_i == idRs2_i)));

    // A freeze suppresses both lower-priority actions; they re-evaluate once the miss ends.
    assign w_lu_fire    = !dcacheStall_i && w_load_use;
    assign w_flush_fire = !dcacheStall_i && !w_load_use && branchTaken_i;

    always_comb begin
        w_ctrl = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0,
                   ifid_flush: 1'b0, all_stall: 1'b0};
        if (!rst_i) begin
            // Hold the front end and keep NOPs flowing while in reset.
            w_ctrl.pc_write    = 1'b0;
            w_ctrl.ifid_write  = 1'b0;
            w_ctrl.idex_bubble = 1'b1;
        end else if (dcacheStall_i) begin
            w_ctrl.pc_write   = 1'b0;
            w_ctrl.ifid_write = 1'b0;
            w_ctrl.all_stall  = 1'b1;
        end else if (w_load_use) begin
            w_ctrl.pc_write    = 1'b0;
            w_ctrl.ifid_write  = 1'b0;
            w_ctrl.idex_bubble = 1'b1;
        end else if (branchTaken_i) begin
            w_ctrl.ifid_flush = 1'b1;
        end
    end

    assign pcWrite_o    = w_ctrl.pc_write;
    assign ifidWrite_o  = w_ctrl.ifid_write;
    assign idexBubble_o = w_ctrl.idex_bubble;
    assign ifidFlush_o  = w_ctrl.ifid_flush;
    assign allStall_o   = w_ctrl.all_stall;

    // Miss tracker state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Miss tracker next state; waitCnt is the length of the current miss in cycles.
    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_miss_start  = 1'b0;
        w_timeout_set = 1'b0;
        case (r_state)
            RUN: begin
                if (dcacheStall_i) begin
                    w_state_nxt   = MISS_WAIT;
                    w_wait_nxt    = 16'd1;
                    w_miss_start  = 1'b1;
                    w_timeout_set = (MISS_TIMEOUT == 1);
                end
            end
            MISS_WAIT: begin
                if (dcacheStall_i) begin
                    if (r_wait_cnt != WAIT_CNT_MAX) begin
                        w_wait_nxt = r_wait_cnt + 16'd1;
                    end
                    // 17-bit compare so the saturated value cannot alias onto a small timeout.
                    w_timeout_set = (({1'b0, r_wait_cnt} + 17'd1) == 17'(MISS_TIMEOUT));
                end else begin
                    w_state_nxt = RUN;
                    w_wait_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // Sticky until reset; the counter clear deliberately leaves it alone.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_set) begin
            r_timeout <= 1'b1;
        end
    end

    assign missTimeout_o = r_timeout;

    sat_counter #(.W(CNT_W)) u_cnt_stall (
        .clk_i (clk_i), .rst_i (rst_i), .inc (w_ctrl.all_stall), .clr (clrCnt_i), .q (stallCycles_o)
    );

    sat_counter #(.W(CNT_W)) u_cnt_miss (
        .clk_i (clk_i), .rst_i (rst_i), .inc (w_miss_start), .clr (clrCnt_i), .q (missCnt_o)
    );

    sat_counter #(.W(CNT_W)) u_cnt_load_use (
        .clk_i (clk_i), .rst_i (rst_i), .inc (w_lu_fire), .clr (clrCnt_i), .q (loadUseCnt_o)
    );

    sat_counter #(.W(CNT_W)) u_cnt_flush (
        .clk_i (clk_i), .rst_i (rst_i), .inc (w_flush_fire), .clr (clrCnt_i), .q (flushCnt_o)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two configurations driven in lockstep from shared inputs.
// Instance A is small (3-bit counters, timeout 4), instance B wide (32-bit counters, timeout 1).
// Expected values come from an event-level model: true event counts, current miss length.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, ex_rd;
    logic       uses_rs2, ex_load, br_taken, dc_stall, clr_cnt;

    logic        a_pc, a_ifid, a_bub, a_flush, a_all, a_to;
    logic [2:0]  a_stall_c, a_miss_c, a_lu_c, a_flush_c;
    logic        b_pc, b_ifid, b_bub, b_flush, b_all, b_to;
    logic [31:0] b_stall_c, b_miss_c, b_lu_c, b_flush_c;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: unbounded event counts since last clear, current miss length.
    int m_stall, m_miss, m_lu, m_flush;
    int m_run_len;
    bit m_to_a, m_to_b;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(3), .MISS_TIMEOUT(4)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .idRs1_i(rs1), .idRs2_i(rs2), .idUsesRs2_i(uses_rs2),
        .exMemRead_i(ex_load), .exRd_i(ex_rd), .branchTaken_i(br_taken), .dcacheStall_i(dc_stall),
        .clrCnt_i(clr_cnt), .pcWrite_o(a_pc), .ifidWrite_o(a_ifid), .idexBubble_o(a_bub),
        .ifidFlush_o(a_flush), .allStall_o(a_all), .missTimeout_o(a_to), .stallCycles_o(a_stall_c),
        .missCnt_o(a_miss_c), .loadUseCnt_o(a_lu_c), .flushCnt_o(a_flush_c)
    );

    hazard_stall_ctrl #(.CNT_W(32), .MISS_TIMEOUT(1)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .idRs1_i(rs1), .idRs2_i(rs2), .idUsesRs2_i(uses_rs2),
        .exMemRead_i(ex_load), .exRd_i(ex_rd), .branchTaken_i(br_taken), .dcacheStall_i(dc_stall),
        .clrCnt_i(clr_cnt), .pcWrite_o(b_pc), .ifidWrite_o(b_ifid), .idexBubble_o(b_bub),
        .ifidFlush_o(b_flush), .allStall_o(b_all), .missTimeout_o(b_to), .stallCycles_o(b_stall_c),
        .missCnt_o(b_miss_c), .loadUseCnt_o(b_lu_c), .flushCnt_o(b_flush_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    function automatic bit is_load_use();
        if (!ex_load || ex_rd == 5'd0) return 1'b0;
        return (ex_rd == rs1) || (uses_rs2 && ex_rd == rs2);
    endfunction

    // Expected {pcWrite, ifidWrite, idexBubble, ifidFlush, allStall}.
    function automatic logic [4:0] exp_ctrl();
        if (!rst_n)        return 5'b00100;
        if (dc_stall)      return 5'b00001;
        if (is_load_use()) return 5'b00100;
        if (br_taken)      return 5'b11010;
        return 5'b11000;
    endfunction

    task automatic model_reset();
        m_stall = 0; m_miss = 0; m_lu = 0; m_flush = 0;
        m_run_len = 0; m_to_a = 1'b0; m_to_b = 1'b0;
    endtask

    // Account for the cycle whose inputs are present at this rising edge.
    task automatic model_step();
        if (!rst_n) return;
        m_run_len = dc_stall ? m_run_len + 1 : 0;
        if (m_run_len >= 4) m_to_a = 1'b1;
        if (m_run_len >= 1) m_to_b = 1'b1;
        if (clr_cnt) begin
            m_stall = 0; m_miss = 0; m_lu = 0; m_flush = 0;
        end else begin
            if (dc_stall) m_stall++;
            if (m_run_len == 1) m_miss++;
            if (!dc_stall && is_load_use()) m_lu++;
            if (!dc_stall && !is_load_use() && br_taken) m_flush++;
        end
    endtask

    task automatic chk_comb();
        chk("ctrl_a", {27'd0, a_pc, a_ifid, a_bub, a_flush, a_all}, {27'd0, exp_ctrl()});
        chk("ctrl_b", {27'd0, b_pc, b_ifid, b_bub, b_flush, b_all}, {27'd0, exp_ctrl()});
    endtask

    task automatic chk_regs();
        chk("stall_cnt_a", {29'd0, a_stall_c}, sat3(m_stall));
        chk("miss_cnt_a",  {29'd0, a_miss_c},  sat3(m_miss));
        chk("lu_cnt_a",    {29'd0, a_lu_c},    sat3(m_lu));
        chk("flush_cnt_a", {29'd0, a_flush_c}, sat3(m_flush));
        chk("timeout_a",   {31'd0, a_to},      {31'd0, m_to_a});
        chk("stall_cnt_b", b_stall_c, m_stall);
        chk("miss_cnt_b",  b_miss_c,  m_miss);
        chk("lu_cnt_b",    b_lu_c,    m_lu);
        chk("flush_cnt_b", b_flush_c, m_flush);
        chk("timeout_b",   {31'd0, b_to}, {31'd0, m_to_b});
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic tick();
        #1;
        chk_comb();
        chk_regs();
        @(posedge clk);
        model_step();
        #1;
        chk_regs();
        @(negedge clk);
    endtask

    task automatic set_idle();
        rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0; uses_rs2 = 1'b0;
        ex_load = 1'b0; br_taken = 1'b0; dc_stall = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic clear_cycle();
        set_idle();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        chk_comb();
        chk_regs();
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use on rs1, then the same with rd = x0.
        ex_load = 1'b1; ex_rd = 5'd5; rs1 = 5'd5;
        #1 chk("lu_pc", {31'd0, a_pc}, 32'd0);
        chk("lu_bubble", {31'd0, a_bub}, 32'd1);
        tick();
        chk("lu_cnt_after", {29'd0, a_lu_c}, 32'd1);
        ex_rd = 5'd0; rs1 = 5'd0;
        #1 chk("x0_no_stall", {31'd0, a_pc}, 32'd1);
        tick();

        // rs2 only matters when the ID instruction reads it.
        ex_load = 1'b1; ex_rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; uses_rs2 = 1'b0;
        #1 chk("rs2_unused", {31'd0, a_pc}, 32'd1);
        tick();
        uses_rs2 = 1'b1;
        #1 chk("rs2_used", {31'd0, a_pc}, 32'd0);
        tick();

        // Branch coincident with load-use: the load-use wins, branch re-resolves next cycle.
        clear_cycle();
        ex_load = 1'b1; ex_rd = 5'd5; rs1 = 5'd5; br_taken = 1'b1;
        #1 chk("br_lu_flush", {31'd0, a_flush}, 32'd0);
        tick();
        ex_load = 1'b0;
        #1 chk("br_flush", {31'd0, a_flush}, 32'd1);
        tick();
        chk("br_flush_cnt", {29'd0, a_flush_c}, 32'd1);

        // Counter saturation and clear-beats-increment.
        clear_cycle();
        br_taken = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("flush_sat_a", {29'd0, a_flush_c}, 32'd7);
        chk("flush_b_9", b_flush_c, 32'd9);
        clr_cnt = 1'b1;
        tick();
        chk("flush_clr", {29'd0, a_flush_c}, 32'd0);

        // Miss timeout: 3-cycle miss stays under, 4-cycle miss trips it; clear leaves it set.
        set_idle();
        dc_stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        dc_stall = 1'b0;
        tick();
        chk("to_short", {31'd0, a_to}, 32'd0);
        dc_stall = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("to_long", {31'd0, a_to}, 32'd1);
        dc_stall = 1'b0; clr_cnt = 1'b1;
        tick();
        chk("to_sticky", {31'd0, a_to}, 32'd1);
        clr_cnt = 1'b0; dc_stall = 1'b1;
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_to", {31'd0, a_to}, 32'd0);
        chk("rst_stall_cnt", {29'd0, a_stall_c}, 32'd0);
        chk("rst_pc", {31'd0, a_pc}, 32'd0);
        chk("rst_bubble", {31'd0, a_bub}, 32'd1);
        chk_comb();
        chk_regs();
        @(negedge clk);
        rst_n = 1'b1;
        dc_stall = 1'b0;
        tick();

        // Freeze overrides a pending load-use; the bubble appears once the miss ends.
        ex_load = 1'b1; ex_rd = 5'd5; rs1 = 5'd5; dc_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("miss_all", {31'd0, a_all}, 32'd1);
            chk("miss_nobub", {31'd0, a_bub}, 32'd0);
            tick();
        end
        chk("miss_stall_cnt", {29'd0, a_stall_c}, 32'd5);
        chk("miss_cnt", {29'd0, a_miss_c}, 32'd1);
        dc_stall = 1'b0;
        #1 chk("miss_release_bub", {31'd0, a_bub}, 32'd1);
        tick();

        // Randomized traffic, including back-to-back misses and occasional resets.
        set_idle();
        for (int i = 0; i < 400; i++) begin
            rs1      = 5'($urandom_range(0, 3));
            rs2      = 5'($urandom_range(0, 3));
            ex_rd    = 5'($urandom_range(0, 3));
            uses_rs2 = 1'($urandom_range(0, 1));
            ex_load  = 1'($urandom_range(0, 1));
            br_taken = ($urandom_range(0, 9) < 3);
            clr_cnt  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) < 3) dc_stall = ~dc_stall;
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                chk_comb();
                chk_regs();
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
